// File: rtl/mips16_pkg.sv
// Shared definitions for the mips16 pipeline register-file slice:
// default datapath sizes and the clear-sequencer state encoding.
package mips16_pkg;

  // Default datapath sizes shared with the rest of the pipeline.
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 16;

  // CLEAR zeroes the array one entry per cycle after reset; RUN is normal operation.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  // True when an address names the hard-wired zero register.
  function automatic logic is_zero_addr(input logic zero_en, input logic [31:0] addr);
    return zero_en && (addr == 32'd0);
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when a producer issues,
// cleared when its write commits, and looked up per read port as a busy flag.
module reg_file_scoreboard
  import mips16_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_run,
  input  logic                     i_iss_valid,
  input  logic [ADDR_W-1:0]        i_iss_addr,
  input  logic                     i_we0,
  input  logic [ADDR_W-1:0]        i_waddr0,
  input  logic                     i_we1,
  input  logic [ADDR_W-1:0]        i_waddr1,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]        o_rd_busy
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;

  // Next pending vector: clears from committed writes first, then the issue set,
  // so a new producer issued in the same cycle supersedes the one completing.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' with a default assigned first,
    // so later statements override earlier ones and no latch is inferred.
    w_pending_nxt = r_pending;
    if (i_run) begin
      if (i_we0)       w_pending_nxt[i_waddr0]   = 1'b0;
      if (i_we1)       w_pending_nxt[i_waddr1]   = 1'b0;
      if (i_iss_valid) w_pending_nxt[i_iss_addr] = 1'b1;
    end
    if (ZERO_EN) w_pending_nxt[0] = 1'b0;
  end

  // Pending register; reset clears every bit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking '<=' only, so every
    // flop samples the pre-edge values of its sources.
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Busy lookup per read port; a same-cycle write is being bypassed, so it is not busy.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    logic [ADDR_W-1:0] w_addr;
    logic              w_wr_hit;
    assign w_addr   = i_rd_addr[k*ADDR_W +: ADDR_W];
    assign w_wr_hit = (i_we0 && (i_waddr0 == w_addr)) || (i_we1 && (i_waddr1 == w_addr));
    assign o_rd_busy[k] = i_run && r_pending[w_addr] && !w_wr_hit;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port ID-stage register file: NUM_RD combinational read ports with
// write-to-read bypass, two write ports (port 1 wins on a collision), a
// post-reset clear sequencer and a pending-write scoreboard.
module reg_file_mp
  import mips16_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr
);

  localparam logic              ZERO_EN  = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_ready;
  logic              w_ready_nxt;

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  logic w_run;
  logic w_we0;
  logic w_we1;
  logic w_iss;

  assign w_run = (r_state == ST_RUN);

  // Effective write/issue strobes: ignored during CLEAR, and the zero register
  // is never a write target.
  assign w_we0 = w_run && we0 && !is_zero_addr(ZERO_EN, 32'(waddr0));
  assign w_we1 = w_run && we1 && !is_zero_addr(ZERO_EN, 32'(waddr1));
  assign w_iss = w_run && iss_valid;

  assign ready = r_ready;

  // Clear-sequencer next state: walk every index once, then enter RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = ST_RUN;
          w_ready_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  // Clear-sequencer state register; reset restarts the sequence from index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Array update: zero one entry per CLEAR cycle, otherwise commit writes with
  // port 1 last so it wins an address collision.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch so it maps onto plain RAM/flops
    // without a reset net; the CLEAR walk supplies the defined contents.
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_cnt] <= '0;
      end else begin
        if (w_we0) r_mem[waddr0] <= wdata0;
        if (w_we1) r_mem[waddr1] <= wdata1;
      end
    end
  end

  // Read ports: zero during CLEAR and for the zero register, otherwise bypass
  // a same-cycle write (port 1 first) before falling back to the array.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = r_mem[w_addr];
      if (!w_run || is_zero_addr(ZERO_EN, 32'(w_addr))) begin
        w_data = '0;
      end else if (w_we1 && (waddr1 == w_addr)) begin
        w_data = wdata1;
      end else if (w_we0 && (waddr0 == w_addr)) begin
        w_data = wdata0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = w_data;
  end

  reg_file_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_run       (w_run),
    .i_iss_valid (w_iss),
    .i_iss_addr  (iss_addr),
    .i_we0       (w_we0),
    .i_waddr0    (waddr0),
    .i_we1       (w_we1),
    .i_waddr1    (waddr1),
    .i_rd_addr   (rd_addr),
    .o_rd_busy   (rd_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default instance (A), ZERO_REG=0 instance (B)
// and a 32x32-bit, 3-read-port instance (C), all on one clock.
module tb_reg_file_mp;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  // Instance A: defaults.
  logic        rst_a, ready_a, we0_a, we1_a, iss_valid_a;
  logic [7:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [3:0]  waddr0_a, waddr1_a, iss_addr_a;
  logic [15:0] wdata0_a, wdata1_a;

  // Instance B: ZERO_REG = 0.
  logic        rst_b, ready_b, we0_b, we1_b, iss_valid_b;
  logic [7:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic [1:0]  rd_busy_b;
  logic [3:0]  waddr0_b, waddr1_b, iss_addr_b;
  logic [15:0] wdata0_b, wdata1_b;

  // Instance C: 32 registers, 3 read ports, 32-bit data.
  logic        rst_c, ready_c, we0_c, we1_c, iss_valid_c;
  logic [14:0] rd_addr_c;
  logic [95:0] rd_data_c;
  logic [2:0]  rd_busy_c;
  logic [4:0]  waddr0_c, waddr1_c, iss_addr_c;
  logic [31:0] wdata0_c, wdata1_c;

  reg_file_mp u_a (
    .clk(clk), .rst(rst_a), .ready(ready_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .we0(we0_a), .waddr0(waddr0_a), .wdata0(wdata0_a),
    .we1(we1_a), .waddr1(waddr1_a), .wdata1(wdata1_a),
    .iss_valid(iss_valid_a), .iss_addr(iss_addr_a)
  );

  reg_file_mp #(.ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst_b), .ready(ready_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .we0(we0_b), .waddr0(waddr0_b), .wdata0(wdata0_b),
    .we1(we1_b), .waddr1(waddr1_b), .wdata1(wdata1_b),
    .iss_valid(iss_valid_b), .iss_addr(iss_addr_b)
  );

  reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(3)) u_c (
    .clk(clk), .rst(rst_c), .ready(ready_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .rd_busy(rd_busy_c), .we0(we0_c), .waddr0(waddr0_c), .wdata0(wdata0_c),
    .we1(we1_c), .waddr1(waddr1_c), .wdata1(wdata1_c),
    .iss_valid(iss_valid_c), .iss_addr(iss_addr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register dump of instance A through hierarchical access.
  task automatic dump_regs_a();
    for (int i = 0; i < 16; i++) $display("  A r%0d = %h", i, u_a.r_mem[i]);
  endtask

  initial begin
    rst_a = 1'b1; rd_addr_a = '0; we0_a = 0; waddr0_a = '0; wdata0_a = '0;
    we1_a = 0; waddr1_a = '0; wdata1_a = '0; iss_valid_a = 0; iss_addr_a = '0;
    rst_b = 1'b1; rd_addr_b = '0; we0_b = 0; waddr0_b = '0; wdata0_b = '0;
    we1_b = 0; waddr1_b = '0; wdata1_b = '0; iss_valid_b = 0; iss_addr_b = '0;
    rst_c = 1'b1; rd_addr_c = '0; we0_c = 0; waddr0_c = '0; wdata0_c = '0;
    we1_c = 0; waddr1_c = '0; wdata1_c = '0; iss_valid_c = 0; iss_addr_c = '0;

    // Reset held for 3 edges.
    repeat (3) tick();
    check("rst_ready_a", ready_a, 0);
    check("rst_ready_c", ready_c, 0);
    check("rst_data_a", rd_data_a, 0);
    check("rst_busy_a", rd_busy_a, 0);

    // Release; A gets garbage writes/issues during CLEAR which must be ignored.
    rst_a = 0; rst_b = 0; rst_c = 0;
    we0_a = 1; waddr0_a = 4'd3; wdata0_a = 16'hBEEF;
    we1_a = 1; waddr1_a = 4'd5; wdata1_a = 16'hCAFE;
    iss_valid_a = 1; iss_addr_a = 4'd4;
    rd_addr_a = {4'd4, 4'd3};
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i <= 16) check($sformatf("clr_ready_a_%0d", i), ready_a, (i == 16) ? 1 : 0);
      if (i == 8) begin
        check("clr_data_a", rd_data_a, 0);
        check("clr_busy_a", rd_busy_a, 0);
      end
      if (i == 15) check("clr_ready_b_15", ready_b, 0);
      if (i == 16) begin
        check("clr_ready_b_16", ready_b, 1);
        we0_a = 0; we1_a = 0; iss_valid_a = 0;
      end
      check($sformatf("clr_ready_c_%0d", i), ready_c, (i == 32) ? 1 : 0);
    end

    // All 16 registers of A read 0; garbage writes and issues left no trace.
    for (int r = 0; r < 16; r++) begin
      rd_addr_a = {4'(r), 4'(r)};
      #1;
      check($sformatf("clr_reg_a_%0d", r), rd_data_a[15:0], 0);
    end
    rd_addr_a = {4'd4, 4'd3};
    #1;
    check("clr_busy4_a", rd_busy_a, 2'b00);

    // Write/read/bypass on port 0.
    tick();
    we0_a = 1; waddr0_a = 4'd5; wdata0_a = 16'h1234; rd_addr_a = {4'd0, 4'd5};
    #1;
    check("byp_w5", rd_data_a[15:0], 16'h1234);
    tick();
    we0_a = 0;
    #1;
    check("rd_r5", rd_data_a[15:0], 16'h1234);

    // Dual-write conflict: port 1 wins, for both bypass and commit.
    we0_a = 1; waddr0_a = 4'd7; wdata0_a = 16'hAAAA;
    we1_a = 1; waddr1_a = 4'd7; wdata1_a = 16'h5555;
    rd_addr_a = {4'd0, 4'd7};
    #1;
    check("conf_byp_r7", rd_data_a[15:0], 16'h5555);
    tick();
    we0_a = 0; we1_a = 0;
    #1;
    check("conf_rd_r7", rd_data_a[15:0], 16'h5555);
    we0_a = 1; waddr0_a = 4'd3; wdata0_a = 16'h0011;
    we1_a = 1; waddr1_a = 4'd4; wdata1_a = 16'h0022;
    rd_addr_a = {4'd4, 4'd3};
    #1;
    check("dual_byp_r3", rd_data_a[15:0], 16'h0011);
    check("dual_byp_r4", rd_data_a[31:16], 16'h0022);
    tick();
    we0_a = 0; we1_a = 0;
    #1;
    check("dual_rd_r3", rd_data_a[15:0], 16'h0011);
    check("dual_rd_r4", rd_data_a[31:16], 16'h0022);

    // Scoreboard: issue 9, then see busy on both ports.
    iss_valid_a = 1; iss_addr_a = 4'd9;
    tick();
    iss_valid_a = 0; rd_addr_a = {4'd9, 4'd9};
    #1;
    check("sb_busy9", rd_busy_a, 2'b11);
    we0_a = 1; waddr0_a = 4'd9; wdata0_a = 16'h00FF;
    #1;
    check("sb_wr_busy9", rd_busy_a, 2'b00);
    check("sb_wr_data9", rd_data_a[15:0], 16'h00FF);
    tick();
    we0_a = 0;
    #1;
    check("sb_clr_busy9", rd_busy_a, 2'b00);
    check("sb_clr_data9", rd_data_a[15:0], 16'h00FF);
    iss_valid_a = 1; iss_addr_a = 4'd9;
    we1_a = 1; waddr1_a = 4'd9; wdata1_a = 16'h1111;
    #1;
    check("sb_setwin_now", rd_busy_a, 2'b00);
    tick();
    iss_valid_a = 0; we1_a = 0;
    #1;
    check("sb_setwin_busy", rd_busy_a, 2'b11);
    check("sb_setwin_data", rd_data_a[31:16], 16'h1111);

    // Zero register on A: write and issue to 0 are dropped.
    we0_a = 1; waddr0_a = 4'd0; wdata0_a = 16'hFFFF;
    iss_valid_a = 1; iss_addr_a = 4'd0; rd_addr_a = {4'd9, 4'd0};
    #1;
    check("z_a_byp_data", rd_data_a[15:0], 0);
    check("z_a_byp_busy", rd_busy_a[0], 0);
    tick();
    we0_a = 0; iss_valid_a = 0;
    #1;
    check("z_a_data", rd_data_a[15:0], 0);
    check("z_a_busy", rd_busy_a[0], 0);

    // Same on B (ZERO_REG=0): register 0 is ordinary.
    we0_b = 1; waddr0_b = 4'd0; wdata0_b = 16'hFFFF;
    iss_valid_b = 1; iss_addr_b = 4'd0; rd_addr_b = {4'd0, 4'd0};
    #1;
    check("z_b_byp_data", rd_data_b[15:0], 16'hFFFF);
    check("z_b_byp_busy", rd_busy_b[0], 0);
    tick();
    we0_b = 0; iss_valid_b = 0;
    #1;
    check("z_b_data", rd_data_b[15:0], 16'hFFFF);
    check("z_b_busy", rd_busy_b[0], 1);

    // Mid-operation reset on A.
    we0_a = 1; waddr0_a = 4'd2; wdata0_a = 16'h0042;
    iss_valid_a = 1; iss_addr_a = 4'd6;
    tick();
    we0_a = 0; iss_valid_a = 0; rd_addr_a = {4'd6, 4'd2};
    #1;
    check("mr_pre_r2", rd_data_a[15:0], 16'h0042);
    check("mr_pre_busy6", rd_busy_a[1], 1);
    rst_a = 1;
    tick();
    rst_a = 0;
    #1;
    check("mr_ready", ready_a, 0);
    check("mr_busy6", rd_busy_a[1], 0);
    check("mr_r2", rd_data_a[15:0], 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("mr_ready_%0d", i), ready_a, (i == 16) ? 1 : 0);
      if (i < 16) check($sformatf("mr_r2_%0d", i), rd_data_a[15:0], 0);
    end
    check("mr_post_r2", rd_data_a[15:0], 0);
    check("mr_post_busy6", rd_busy_a[1], 0);

    // Instance C: write/bypass on read port 2, then mid-operation reset.
    we1_c = 1; waddr1_c = 5'd31; wdata1_c = 32'hDEADBEEF;
    rd_addr_c = {5'd31, 5'd1, 5'd0};
    #1;
    check("c_byp_r31", rd_data_c[95:64], 32'hDEADBEEF);
    tick();
    we1_c = 0;
    #1;
    check("c_rd_r31", rd_data_c[95:64], 32'hDEADBEEF);
    iss_valid_c = 1; iss_addr_c = 5'd1;
    tick();
    iss_valid_c = 0;
    #1;
    check("c_busy1", rd_busy_c, 3'b010);
    rst_c = 1;
    tick();
    rst_c = 0;
    #1;
    check("c_mr_ready", ready_c, 0);
    check("c_mr_busy", rd_busy_c, 3'b000);
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i >= 31) check($sformatf("c_mr_ready_%0d", i), ready_c, (i == 32) ? 1 : 0);
    end
    check("c_mr_r31", rd_data_c[95:64], 0);

    dump_regs_a();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the 16-bit pipeline register file: NUM_RD combinational read ports, two write ports, and write-to-read bypass.
- Adds a pending-write scoreboard for hazard detection and a post-reset clear sequencer that zeroes the array one entry per cycle.
- Sits in the ID stage. Read ports feed operand muxes. Write port 0 serves WB; write port 1 serves a second writeback source such as a load/multiply unit.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 16, number of registers; power of two, at least 4. Localparam ADDR_W = $clog2(NUM_REGS).
- NUM_RD, 2, number of read ports, 1 to 4.
- ZERO_REG, 1, when 1, register 0 always reads 0, is never written, and is never marked pending.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high once the clear sequence is complete.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data for each port, combinational.
- rd_busy  out  NUM_RD  pending-write flag for each read port, combinational.
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1.
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- iss_valid  in  1  an instruction that will write iss_addr is issuing; marks it pending.
- iss_addr  in  ADDR_W  destination register being issued.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to CLEAR, clear counter goes to 0, all pending bits go to 0, ready goes to 0.
  - Array contents are not reset directly; the clear sequence zeroes them.
  - Reset is honoured from any state, including mid-CLEAR; the sequence restarts at index 0.
- CLEAR state:
  - Each edge with rst=0 writes 0 to entry cnt, then increments cnt.
  - When cnt = NUM_REGS-1 is written, the FSM moves to RUN and ready=1 from the next cycle.
  - ready is therefore high exactly NUM_REGS edges after the first edge with rst low.
  - we0, we1 and iss_valid are ignored.
  - rd_data reads 0 and rd_busy reads 0 on all ports.
- RUN state:
  - Writes commit at the edge when weN=1. With ZERO_REG=1, writes to address 0 are dropped.
  - If we0 and we1 target the same address in the same cycle, port 1 wins.
  - Read bypass: if a read address matches an active same-cycle write, rd_data returns that write data, port 1 taking priority over port 0. Otherwise it returns the array entry.
  - With ZERO_REG=1, address 0 always reads 0, including when a bypass match exists.
- Scoreboard (NUM_REGS pending bits, RUN only):
  - iss_valid sets pending[iss_addr].
  - Any committed write to address A clears pending[A].
  - If iss_addr equals a write address in the same cycle, set wins: a new producer supersedes the one completing.
  - rd_busy[k] = pending[rd_addr_k] AND NOT (same-cycle write to rd_addr_k), so bypassed data is never flagged busy.
  - With ZERO_REG=1, address 0 is never pending.
- Timing: zero read latency and one-cycle write latency; ready and the pending bits are registered.
- No X propagation: every output is defined from the first cycle after reset.

Decomposition:
- Shared package (mips16_pkg) holds the FSM state enum {CLEAR, RUN} and the default DATA_W/NUM_REGS constants shared with the pipeline.
- One natural sub-module, reg_file_scoreboard: the pending bits, issue/clear logic and busy lookup, parametrised on NUM_REGS/NUM_RD/ZERO_REG.
- The array, bypass and clear FSM stay in the top module.
- The register-dump debug task moves to the bench, using hierarchical access.

Test Plan:
- Clear sequence: hold rst for 3 cycles with defaults, release, and pre-load garbage by forcing we0 during CLEAR. Expect ready=0 for 16 edges and 1 on the 16th; all 16 registers read 0; the garbage writes are ignored.
- Write/read/bypass: we0 with waddr0=5, wdata0=0x1234, rd_addr port0=5 in the same cycle. Expect rd_data0=0x1234 combinationally, and 0x1234 again next cycle with we0=0.
- Dual-write conflict: we0 with (7, 0xAAAA) and we1 with (7, 0x5555) together. Expect bypass of 0x5555 and reg7=0x5555 afterwards. Then we0 with (3, 0x0011) and we1 with (4, 0x0022): both commit.
- Scoreboard: iss_valid with iss_addr=9, then read 9 next cycle: rd_busy=1. Write 9 with 0x00FF: rd_busy=0 in that same cycle and data is 0x00FF. iss_valid=9 together with we1 to 9: pending stays 1.
- Zero register: we0 with (0, 0xFFFF) plus iss_valid with iss_addr=0. Expect rd_data=0, rd_busy=0. Repeat with ZERO_REG=0: reg0=0xFFFF.
- Mid-operation reset: write reg2=0x0042, set pending on 6, assert rst for 1 cycle. Expect ready=0, rd_busy=0 for address 6, and reg2 reads 0 throughout the clear; after the new 16-cycle sequence reg2=0. Also repeat with NUM_REGS=32, NUM_RD=3, DATA_W=32 (ready after 32 edges).
